// File: rtl/event_pkg.sv
// event_pkg: shared state type, default widths and saturating increment for the event discriminator
package event_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [1:0] {BELOW, QUAL, ABOVE, HOLDOFF} state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return v >= max ? max : v + 32'd1;
  endfunction
endpackage

// File: rtl/event_holdoff_timer.sv
// event_holdoff_timer: loadable down-counter flagging when the dead time has elapsed
module event_holdoff_timer import event_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             run,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  // clear wins, then load, then count down to zero while running
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= clr ? '0 : load ? load_val : (run && cnt != '0) ? cnt - 1'b1 : cnt;
  assign done = cnt == '0;
endmodule

// File: rtl/event_discriminator.sv
// event_discriminator: threshold/hysteresis/width-qualified event strobes with holdoff and missed counting
module event_discriminator import event_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [DATA_W-1:0] threshold,
  input  logic [DATA_W-1:0] hysteresis,
  input  logic [CNT_W-1:0]  min_width,
  input  logic [CNT_W-1:0]  holdoff,
  input  logic              edge_sel,
  input  logic              enable,
  input  logic              clear,
  output logic              event_strobe,
  output logic              event_level,
  output logic [CNT_W-1:0]  missed_count
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state, state_n;
  logic [DATA_W-1:0] s_q;
  logic [CNT_W-1:0] wcnt, wnext;
  logic signed [DATA_W+1:0] lower;
  logic hi, lo, hi_q, qual_done, strobe_n, load, done, rise;
  // lower level is two bits wider so a deep hysteresis below the most negative sample disables lo
  assign lower = $signed({{2{threshold[DATA_W-1]}}, threshold}) - $signed({2'b00, hysteresis});
  assign hi = $signed(s_q) >= $signed(threshold);
  assign lo = $signed({{2{s_q[DATA_W-1]}}, s_q}) < lower;
  assign wnext = wcnt + 1'b1;
  assign qual_done = hi && ((state == BELOW && min_width == '0) || (state == QUAL && wnext >= min_width));
  assign rise = state == HOLDOFF && hi && !hi_q;
  assign event_level = state == ABOVE;
  event_holdoff_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .reset(reset),
    .clr(!enable),
    .load(load),
    .load_val(holdoff),
    .run(state == HOLDOFF),
    .done(done)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= BELOW;
    else state <= state_n;
  // next state: qualification, arming, dead time
  always_comb begin
    state_n = state;
    if (!enable) state_n = BELOW;
    else
      case (state)
        BELOW:   if (hi) state_n = qual_done ? (edge_sel ? ABOVE : HOLDOFF) : QUAL;
        QUAL:    if (!hi) state_n = BELOW;
                 else if (qual_done) state_n = edge_sel ? ABOVE : HOLDOFF;
        ABOVE:   if (lo) state_n = edge_sel ? HOLDOFF : BELOW;
        HOLDOFF: if (done) state_n = hi ? ABOVE : BELOW;
        default: state_n = BELOW;
      endcase
  end
  // outputs: strobe on the selected crossing, timer load on holdoff entry
  always_comb begin
    strobe_n = enable && ((qual_done && !edge_sel) || (state == ABOVE && lo && edge_sel));
    load = state != HOLDOFF && state_n == HOLDOFF;
  end
  // sample register, width counter, registered strobe and missed counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s_q <= '0;
      hi_q <= 1'b0;
      wcnt <= '0;
      event_strobe <= 1'b0;
      missed_count <= '0;
    end else begin
      s_q <= sample_in;
      hi_q <= hi;
      wcnt <= (enable && state == QUAL && hi) ? wnext : '0;
      event_strobe <= strobe_n;
      missed_count <= clear ? '0 : rise ? CNT_W'(sat_inc(32'(missed_count), 32'(CNT_MAX))) : missed_count;
    end
endmodule

// File: doc/event_discriminator.md
# event_discriminator

Front-end stage feeding the event counter in the custom-instrument top: converts a signed 16-bit ADC sample stream into clean single-cycle event strobes. Applies a threshold with hysteresis, minimum-width qualification, rising/falling edge selection and a programmable holdoff (dead time). Counts crossings lost to holdoff. Control fields come straight from the instrument's control registers.

## Interface
- DATA_W, 16, sample and threshold width (signed)
- CNT_W, 16, width of min_width, holdoff and missed counter
- clk  in  1  sole clock; all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- sample_in  in  DATA_W  signed ADC sample, one per cycle
- threshold  in  DATA_W  signed upper (arming) level
- hysteresis  in  DATA_W  unsigned; lower level = threshold - hysteresis
- min_width  in  CNT_W  unsigned qualification length in samples
- holdoff  in  CNT_W  unsigned dead time in cycles after each event
- edge_sel  in  1  0 = event on qualified rising crossing, 1 = event on falling crossing
- enable  in  1  0 holds FSM in BELOW, suppresses strobes
- clear  in  1  synchronous clear of missed_count
- event_strobe  out  1  one-cycle pulse per accepted event
- event_level  out  1  1 while FSM in QUAL-completed ABOVE state
- missed_count  out  CNT_W  saturating count of rising crossings during HOLDOFF

## Operation
- sample_in registered to s_q; all comparisons use s_q.
- hi = (s_q >= threshold); lo = (s_q < threshold - hysteresis), lower level computed in DATA_W+2 signed, no wrap. If lower level < -2^(DATA_W-1), lo never asserts (falling crossing unreachable) — required, not an error.
- States (in shared package): BELOW, QUAL, ABOVE, HOLDOFF.
- BELOW: hi -> QUAL, width counter loaded 0; if min_width == 0 treat as immediately qualified (go straight to qualified action below).
- QUAL: hi each cycle increments counter; !hi -> BELOW, no event. Counter == min_width -> qualified: edge_sel=0 -> strobe, HOLDOFF; edge_sel=1 -> ABOVE, no strobe.
- So a rising event needs min_width+1 consecutive samples with hi.
- ABOVE: lo -> edge_sel=1: strobe, HOLDOFF; edge_sel=0: BELOW, no strobe.
- HOLDOFF: holdoff value latched on entry; counts down; input ignored except missed detection. Exit after latched holdoff cycles (holdoff == 0: exits the next cycle); exit to ABOVE if hi else BELOW, never strobes on exit.
- missed_count: +1 each cycle in HOLDOFF where hi is 1 and was 0 the previous cycle; saturates at 2^CNT_W-1; clear wins over simultaneous increment.
- enable low: FSM -> BELOW next cycle, strobe 0, width/holdoff counters zeroed; missed_count retained.
- threshold/hysteresis/min_width/edge_sel are live; holdoff only sampled on HOLDOFF entry.
- event_level = 1 in ABOVE, else 0.

## Timing
- Reset: state BELOW, s_q 0, event_strobe 0, event_level 0, missed_count 0, counters 0. Reset mid-HOLDOFF or mid-QUAL aborts with no strobe.
- Latency: sample_in at edge N, min_width 0, edge_sel 0 -> event_strobe high after edge N+2 (sample register + registered strobe), for exactly one cycle.
- Falling event: first lo sample at edge N -> strobe after edge N+2.
- Max event rate: one strobe per holdoff+2 cycles (edge_sel 0, min_width 0).
- Outputs all registered; no combinational path input -> output.

## Structure
- Package event_pkg: state enum, DATA_W/CNT_W defaults, saturating-increment function.
- One sub-module: event_holdoff_timer (load, count-down, done flag). Rest in one FSM module.

## Test plan
- Reset: assert reset mid-stream -> all outputs 0 same cycle; deassert, sample 1000, thr 500 -> strobe after 2 cycles (min_width 0).
- Qualification: thr 100, min_width 3, samples 200×3 then 0 -> no strobe; 200×4 -> one strobe 2 cycles after fourth sample.
- Hysteresis/falling: thr 100, hyst 50, edge_sel 1; ramp 0->200->60->40 -> single strobe after 40 sample, none at 60.
- Holdoff/missed: holdoff 10, square wave period 4 above thr -> one strobe per 12 cycles, missed_count increments per rising edge in holdoff, saturates at 65535, clear -> 0.
- Boundary: thr -32700, hyst 1000, edge_sel 1 -> ABOVE reached, never strobes; enable low in QUAL -> BELOW, no strobe.
